// File: rtl/ram_2port_if.sv
// Bus bundle for the simple dual-port RAM.
// The master drives the write and read ports; the slave (the RAM) returns q.
interface ram_2port_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] wraddress;
  logic                  wren;
  logic [ADDR_WIDTH-1:0] rdaddress;
  logic                  rden;
  logic [DATA_WIDTH-1:0] q;

  modport master (
    output data,
    output wraddress,
    output wren,
    output rdaddress,
    output rden,
    input  q
  );

  modport slave (
    input  data,
    input  wraddress,
    input  wren,
    input  rdaddress,
    input  rden,
    output q
  );
endinterface

// File: rtl/ram_2port.sv
// Simple dual-port RAM: one write port, one read port, single clock.
// Registered read with old-data read-during-write; reset clears only q.
module ram_2port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clock,
  input  logic        reset,
  ram_2port_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Declaration initialiser gives zeroed contents in simulation and a
  // zero init image on FPGA targets; the array itself has no reset.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge clock) begin
    if (bus.wren) begin
      r_mem[bus.wraddress] <= bus.data;
    end
  end

  // Reads sample the array before this edge's write lands, so a same-address
  // collision returns the old word.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= '0;
    end else if (bus.rden) begin
      r_q <= r_mem[bus.rdaddress];
    end
  end

  assign bus.q = r_q;
endmodule

// File: tb/tb_ram_2port.sv
// Scoreboard bench for ram_2port: expected q pushed per driven cycle,
// popped and compared one edge later against the DUT output.
module tb_ram_2port;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q;
  logic [DW-1:0] sb [$];

  ram_2port_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  ram_2port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_total++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: q=%h expected=%h", tag, obs, expv);
    end else begin
      $display("ok   %s: q=%h", tag, obs);
    end
  endtask

  // One clock of stimulus: drive, push the expected q, apply the write to
  // the model after the read value is captured, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic we,
                      input logic [AW-1:0] wa, input logic [DW-1:0] d,
                      input logic re, input logic [AW-1:0] ra);
    logic [DW-1:0] got;
    logic [DW-1:0] want;
    @(negedge clk);
    rst              = r;
    bus_if.wren      = we;
    bus_if.wraddress = wa;
    bus_if.data      = d;
    bus_if.rden      = re;
    bus_if.rdaddress = ra;
    if (r)       exp_q = '0;
    else if (re) exp_q = model[ra];
    sb.push_back(exp_q);
    if (we) model[wa] = d;
    @(posedge clk);
    #1;
    got  = bus_if.q;
    want = sb.pop_front();
    check(tag, got, want);
  endtask

  initial begin
    logic [AW-1:0] pool [5];
    n_total = 0;
    n_bad   = 0;
    exp_q   = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    pool[0] = 12'd0; pool[1] = 12'd1; pool[2] = 12'd7;
    pool[3] = 12'd2048; pool[4] = 12'd4095;
    rst = 1'b1;
    bus_if.wren = 1'b0; bus_if.rden = 1'b0;
    bus_if.wraddress = '0; bus_if.rdaddress = '0; bus_if.data = '0;

    step("reset",       1, 0, 0, 0, 1, 0);
    step("unwritten0",  0, 0, 0, 0, 1, 12'd100);
    // write then read
    step("wr5",         0, 1, 5, 32'hDEADBEEF, 0, 0);
    step("rd5",         0, 0, 0, 0, 1, 5);
    // read-during-write returns old data
    step("wr7_11",      0, 1, 7, 32'h11, 0, 0);
    step("rdw7_old",    0, 1, 7, 32'h22, 1, 7);
    step("rd7_new",     0, 0, 0, 0, 1, 7);
    // rden hold
    step("wr9_11",      0, 1, 9, 32'h11, 0, 0);
    step("rd9",         0, 0, 0, 0, 1, 9);
    step("hold_a",      0, 1, 10, 32'h99, 0, 5);
    step("hold_b",      0, 1, 9, 32'h77, 0, 10);
    step("hold_c",      0, 0, 0, 0, 0, 7);
    // reset clears q only, and writes during reset still happen
    step("rd5_again",   0, 0, 0, 0, 1, 5);
    step("reset_mid",   1, 1, 12, 32'hCAFEF00D, 1, 5);
    step("after_rst5",  0, 0, 0, 0, 1, 5);
    step("wr_in_rst",   0, 0, 0, 0, 1, 12);
    // address boundaries
    step("wr0",         0, 1, 0, 32'hA5A5A5A5, 0, 0);
    step("wr4095",      0, 1, 12'd4095, 32'h5A5A5A5A, 0, 0);
    step("rd0",         0, 0, 0, 0, 1, 0);
    step("rd4095",      0, 0, 0, 0, 1, 12'd4095);
    // streaming
    step("st_w1",       0, 1, 1, 32'd1, 0, 0);
    step("st_w2",       0, 1, 2, 32'd2, 0, 0);
    step("st_w3",       0, 1, 3, 32'd3, 0, 0);
    step("st_r1",       0, 0, 0, 0, 1, 1);
    step("st_r2",       0, 0, 0, 0, 1, 2);
    step("st_r3",       0, 0, 0, 0, 1, 3);
    // random mix over a small address pool to force collisions
    for (int i = 0; i < 120; i++) begin
      step($sformatf("rnd%0d", i),
           ($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)),
           pool[$urandom_range(0, 4)],
           DW'($urandom),
           1'($urandom_range(0, 1)),
           pool[$urandom_range(0, 4)]);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_2port.md
RAM_2PORT -- requirements
Module: ram_2port

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 12, address width; depth is 2^ADDR_WIDTH words (4096 by default).
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data  input  DATA_WIDTH  write data.
REQ-006 wraddress  input  ADDR_WIDTH  write address.
REQ-007 wren  input  1  write enable.
REQ-008 rdaddress  input  ADDR_WIDTH  read address.
REQ-009 rden  input  1  read enable.
REQ-010 q  output  DATA_WIDTH  registered read data.

Function
REQ-011 The block SHALL be a simple dual-port memory: one independent write port and one independent read port, both on the same clock.
REQ-012 Write: at a rising edge with wren=1, mem[wraddress] SHALL take data; with wren=0, memory SHALL be unchanged.
REQ-013 Read: at a rising edge with rden=1, q SHALL take mem[rdaddress] as it was before that edge (1-cycle latency; the value is visible after the edge).
REQ-014 With rden=0, q SHALL hold its previous value.
REQ-015 Read-during-write to the same address on the same edge SHALL return the old (pre-write) contents; the new value SHALL be readable from the following edge onward.
REQ-016 Simultaneous read and write to different addresses SHALL not interact.
REQ-017 Addresses SHALL use full ADDR_WIDTH decode with no aliasing; every value 0 to 2^ADDR_WIDTH-1 SHALL be valid, and there is no out-of-range case.
REQ-018 Data SHALL be stored and returned bit-exact at DATA_WIDTH with no masking or byte enables.
REQ-019 Memory contents are undefined after power-up until written; an implementation targeting simulation SHALL initialise all words to 0.
REQ-020 Memory SHALL be inferable as block RAM, with no reset on the array and no combinational read path to q.

Reset
REQ-021 While reset=1 at a rising edge, q SHALL become 0 regardless of rden.
REQ-022 Reset SHALL NOT clear or alter memory contents.
REQ-023 Writes with wren=1 during reset SHALL still be performed.
REQ-024 Reset asserted mid-operation SHALL affect only q on that edge; reads resume on the first edge with reset=0 and rden=1.

Verification
REQ-025 Write then read: write 0xDEADBEEF to address 5 at edge N, read address 5 with rden=1 at edge N+1 -> q=0xDEADBEEF after edge N+1.
REQ-026 Read-during-write: mem[7]=0x11, then on one edge write 0x22 to address 7 and read address 7 -> q=0x11; read address 7 on the next edge -> q=0x22.
REQ-027 rden hold: q=0x11, then rden=0 while rdaddress changes and other addresses are written -> q stays 0x11.
REQ-028 Reset: q nonzero, assert reset for one edge -> q=0; then read a previously written address -> original data is intact.
REQ-029 Boundaries: write 0xA5A5A5A5 to address 0 and 0x5A5A5A5A to address 4095 -> reading each returns its own value with no aliasing.
REQ-030 Streaming: write 1,2,3 to addresses 1..3 on consecutive edges, then read addresses 1..3 on consecutive edges with rden=1 -> q sequence is 1,2,3 with 1-cycle latency.
